// File: rtl/dataflow_input_sync_ctrl.sv
// Start/ready synchroniser for the input processes of a dataflow region.
// The top-level ap_start is fanned out to every input process. Each process's
// ap_ready is latched in a ready flag, and start is withheld from a process once
// it has readied. When every process has readied, one top-level ap_ready is issued.
// A watchdog raises a sticky sync stall, with a vector of the blocked processes,
// when a partial-ready state lasts too long.
//
// state   | meaning
// IDLE    | no iteration in flight, waiting for ap_start
// RUN     | iteration started, no process has readied yet
// PARTIAL | some processes have readied, watchdog counting
// STALL   | partial-ready state outlived STALL_LIMIT cycles
module dataflow_input_sync_ctrl #(
  parameter int PROC_NUM    = 2,
  parameter int WD_W        = 16,
  parameter int STALL_LIMIT = 1024,
  parameter int ITER_W      = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic [PROC_NUM-1:0] proc_ap_start,
  input  logic [PROC_NUM-1:0] proc_ap_ready,
  output logic [PROC_NUM-1:0] ready_flag,
  output logic                sync_stall,
  output logic [PROC_NUM-1:0] stall_vec,
  output logic [ITER_W-1:0]   iter_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PARTIAL = 2'd2,
    ST_STALL   = 2'd3
  } state_t;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_LIMIT - 1);

  state_t              state_q, state_d;
  logic [PROC_NUM-1:0] ready_flag_q, ready_flag_d;
  logic [PROC_NUM-1:0] stall_vec_q, stall_vec_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                sync_stall_q, sync_stall_d;

  logic [PROC_NUM-1:0] done;
  logic                all_ready;
  logic                complete;

  // Ready tracking and zero-latency start/ready outputs; reset masks both.
  always_comb begin
    done          = ready_flag_q | proc_ap_ready;
    all_ready     = &done;
    complete      = ap_start & all_ready;
    ap_ready      = complete & ~reset;
    proc_ap_start = reset ? '0 : ({PROC_NUM{ap_start}} & ~ready_flag_q);
  end

  // Next-state: the ready logic only advances while ap_start is high, so a
  // dropped start in PARTIAL/STALL freezes flags, watchdog and state.
  always_comb begin
    state_d      = state_q;
    ready_flag_d = ready_flag_q;
    stall_vec_d  = stall_vec_q;
    wd_d         = wd_q;
    iter_d       = iter_q;
    sync_stall_d = sync_stall_q;

    if (ap_start) begin
      if (all_ready) begin
        // Completion wins over a watchdog expiring in the same cycle.
        state_d      = ST_RUN;
        ready_flag_d = '0;
        stall_vec_d  = '0;
        sync_stall_d = 1'b0;
        wd_d         = '0;
        iter_d       = iter_q + ITER_W'(1);
      end else begin
        // Repeat pulses on an already-set flag are absorbed by the OR.
        ready_flag_d = ready_flag_q | proc_ap_ready;
        unique case (state_q)
          ST_IDLE: state_d = ST_RUN;
          ST_RUN: begin
            if (|done) begin
              state_d = ST_PARTIAL;
              wd_d    = '0;
            end
          end
          ST_PARTIAL: begin
            if (wd_q == WD_LAST) begin
              state_d      = ST_STALL;
              sync_stall_d = 1'b1;
              stall_vec_d  = ready_flag_d;
            end else begin
              wd_d = wd_q + WD_W'(1);
            end
          end
          ST_STALL: stall_vec_d = ready_flag_d;
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q == ST_RUN) begin
      state_d = ST_IDLE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ready_flag_q <= '0;
      stall_vec_q  <= '0;
      wd_q         <= '0;
      iter_q       <= '0;
      sync_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_flag_q <= ready_flag_d;
      stall_vec_q  <= stall_vec_d;
      wd_q         <= wd_d;
      iter_q       <= iter_d;
      sync_stall_q <= sync_stall_d;
    end
  end

  assign ready_flag = ready_flag_q;
  assign stall_vec  = stall_vec_q;
  assign sync_stall = sync_stall_q;
  assign iter_cnt   = iter_q;

endmodule

// File: doc/dataflow_input_sync_ctrl.md
Name: dataflow_input_sync_ctrl

Overview:
- Start/ready synchroniser for the input processes of a dataflow region, e.g. Block_proc and resize_nearest in the myproject top.
- Fans the top-level ap_start out to PROC_NUM input processes and latches each process's ap_ready in a per-process ready flag.
- Withholds start from processes that have already readied until every process has readied, then issues a single top-level ap_ready.
- A watchdog flags prolonged partial-ready states as a sync stall vector, which the simulation deadlock reporting consumes as its dl_in_vec.

Parameters:
PROC_NUM, 2, number of input processes synchronised.
WD_W, 16, watchdog counter width.
STALL_LIMIT, 1024, cycles in PARTIAL before STALL is declared; range 1..2^WD_W-1.
ITER_W, 32, iteration counter width.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
ap_start  in  1  top-level start (ap_ctrl_hs).
ap_ready  out  1  top-level ready; all input processes have accepted the current iteration.
proc_ap_start  out  PROC_NUM  per-process start.
proc_ap_ready  in  PROC_NUM  per-process ready pulses.
ready_flag  out  PROC_NUM  registered per-process ready flags (debug/deadlock use).
sync_stall  out  1  sticky stall indication.
stall_vec  out  PROC_NUM  processes that readied and are blocked waiting on the others; nonzero only in STALL.
iter_cnt  out  ITER_W  completed iterations.

Behaviour:
- Reset (synchronous, high): state=IDLE; ready_flag=0; watchdog=0; iter_cnt=0; sync_stall=0; stall_vec=0.
  - proc_ap_start and ap_ready are forced 0 while reset is high, even if ap_start=1.
- Combinational terms:
  - done[i] = ready_flag[i] | proc_ap_ready[i].
  - all_ready = &done.
  - proc_ap_start[i] = ap_start & ~ready_flag[i] & (state != IDLE or ap_start).
  - Zero latency: start reaches the processes in the same cycle ap_start rises.
- ap_ready = ap_start & all_ready, combinational, high for exactly the completing cycle.
- Flag update each cycle:
  - If ap_start & all_ready: ready_flag <= 0.
  - Else: ready_flag <= ready_flag | (proc_ap_ready & ~ready_flag).
  - A proc_ap_ready pulse while its flag is already set is ignored; it does not count a second iteration.
- iter_cnt increments by 1 on each ap_ready cycle and wraps modulo 2^ITER_W.
- FSM states: IDLE, RUN, PARTIAL, STALL.
  - IDLE: ap_start=1 -> RUN. The ready logic is active in this same cycle, so if all_ready=1 the iteration completes now.
  - RUN:
    - ap_start=0 -> IDLE.
    - all_ready -> stay in RUN; flags cleared.
    - Any done bit set but not all -> PARTIAL; watchdog <= 0.
  - PARTIAL:
    - all_ready -> RUN; flags cleared.
    - Otherwise watchdog += 1.
    - If watchdog == STALL_LIMIT-1 and not all_ready -> STALL; sync_stall <= 1; stall_vec <= ready_flag | proc_ap_ready.
  - STALL:
    - stall_vec tracks the current ready_flag each cycle.
    - all_ready (with ap_start) -> RUN; sync_stall <= 0; stall_vec <= 0.
    - sync_stall is otherwise sticky until reset.
- ap_start falling while in PARTIAL or STALL is a protocol violation. Required response:
  - flags are held;
  - proc_ap_start is 0;
  - the watchdog freezes;
  - state is unchanged;
  - operation resumes when ap_start returns.
- Simultaneous readies:
  - all processes ready in the same cycle -> completion with no PARTIAL visit;
  - the last outstanding ready arriving on the cycle the watchdog expires -> completion wins; STALL is not entered.
- Watchdog width: never wraps; it saturates at STALL_LIMIT-1.
- Reset mid-operation: full return to the reset values on the next edge; partial flags are discarded.

Test Plan:
1. PROC_NUM=2, ap_start held 1, proc_ap_ready=2'b11 on cycle 3 -> ap_ready=1 on cycle 3 only; iter_cnt=1; state RUN; no PARTIAL.
2. proc_ap_ready=01 at cycle 3, then 10 at cycle 7 -> proc_ap_start=10 for cycles 4-7; ready_flag=01 for cycles 4-7; ap_ready pulses at cycle 7; flags back to 00 at cycle 8.
3. STALL_LIMIT=8: only proc 0 readies, at cycle 3 -> STALL entered after 8 PARTIAL cycles; sync_stall=1; stall_vec=01.
   - Proc 1 then readies -> ap_ready pulse; sync_stall and stall_vec return to 0.
4. Proc 0 readies repeatedly (pulses on cycles 3, 4 and 5) while proc 1 is outstanding -> ready_flag stays 01; one ap_ready when proc 1 readies; iter_cnt advances by exactly 1.
5. Reset asserted during PARTIAL with ready_flag=01 -> next cycle: all outputs are reset values.
   - Then ap_start=1 with proc_ap_ready=11 -> ap_ready=1; iter_cnt=1.
6. ap_start dropped during PARTIAL for 5 cycles -> proc_ap_start=00; watchdog value unchanged; resumes and completes when ap_start=1 and proc 1 readies.
